serial_subtractor: RTL

- Bit-serial two's-complement subtractor. Computes diff = a - b for WIDTH-bit operands, one bit per clock.
- Uses a single full-adder cell with a registered carry/borrow, so it is the inverse-operation counterpart of the combinational full-adder datapath.
- Sits beside the ALU as a low-area subtract unit behind a start/done handshake.

---
 rtl/serial_subtractor.sv | 114 +++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: one full-adder cell plus a registered carry, LSB first.
// Optional SERIAL_SUB_ADD_MODE_EN adds a 'mode' input; mode=1 turns the unit into a serial adder.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             start,
`ifdef SERIAL_SUB_ADD_MODE_EN
    input  logic             mode,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrowOut,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FIN
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic             c_msb_in;
    logic [CNT_W-1:0] count;
    logic             add_r;
    logic             start_add;
    logic             sum_bit;
    logic             carry_nxt;
    logic             accept;

`ifdef SERIAL_SUB_ADD_MODE_EN
    assign start_add = mode;
`else
    assign start_add = 1'b0;
`endif

    assign sum_bit   = a_sh[0] ^ b_sh[0] ^ carry;
    assign carry_nxt = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    assign accept    = start && (state == IDLE || state == FIN);

    // FIN still publishes the finished result even when a new start is taken in
    // the same cycle, so done always coincides with valid diff and flags.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            diff      <= '0;
            borrowOut <= 1'b0;
            overflow  <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            carry     <= 1'b0;
            c_msb_in  <= 1'b0;
            count     <= '0;
            add_r     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        diff      <= '0;
                        borrowOut <= 1'b0;
                        overflow  <= 1'b0;
                    end
                end
                SHIFT: begin
                    diff  <= {sum_bit, diff[WIDTH-1:1]};
                    carry <= carry_nxt;
                    a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
                    count <= count + CNT_W'(1);
                    if (count == CNT_W'(WIDTH - 2)) begin
                        c_msb_in <= carry_nxt;
                    end
                    if (count == CNT_W'(WIDTH - 1)) begin
                        state <= FIN;
                        busy  <= 1'b0;
                    end
                end
                FIN: begin
                    done      <= 1'b1;
                    borrowOut <= add_r ? carry : ~carry;
                    overflow  <= c_msb_in ^ carry;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
            if (accept) begin
                a_sh  <= a;
                b_sh  <= start_add ? b : ~b;
                carry <= ~start_add;
                count <= '0;
                add_r <= start_add;
                busy  <= 1'b1;
                state <= SHIFT;
            end
        end
    end

endmodule
